// File: rtl/typing_round_controller_if.sv
// Keyboard/parser handshake bundle for the typing round controller.
// master: keyboard decoder plus word parser; slave: the round controller.
interface typing_round_controller_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] comparison_data;
  logic [7:0] num_char;
  logic       get_next_character;
  logic       enable_next_level;

  modport master (
    output key_valid, key_code, comparison_data, num_char,
    input  get_next_character, enable_next_level
  );

  modport slave (
    input  key_valid, key_code, comparison_data, num_char,
    output get_next_character, enable_next_level
  );
endinterface

// File: rtl/typing_round_controller.sv
// Round sequencer for the speed-typing game: filters PS/2 break/extended
// prefixes, compares makes against the parser's expected code, counts
// progress and mistakes, and steps the parser through NUM_LEVELS words.
// Optional per-word time limit enabled by defining TIMEOUT_EN.
module typing_round_controller #(
  parameter int NUM_LEVELS      = 30,
  parameter int MAX_MISTAKES    = 3,
  parameter int LOAD_DELAY      = 4,
  parameter int TICKS_PER_LEVEL = 500000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  typing_round_controller_if.slave bus,
  output logic [7:0]               chars_typed,
  output logic [7:0]               mistakes,
  output logic [4:0]               level,
  output logic                     playing,
  output logic                     game_over,
  output logic                     game_won,
  output logic                     timeout
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_SHIFT, S_NEXT, S_DONE} state_t;

  localparam logic [4:0] LAST_LEVEL    = 5'(NUM_LEVELS - 1);
  localparam logic [7:0] LOAD_LAST     = 8'(LOAD_DELAY);
  localparam logic [7:0] MISTAKE_LIMIT = 8'(MAX_MISTAKES);

  state_t     state_q, state_d;
  logic       brk_q, brk_d, ext_q, ext_d;
  logic [7:0] load_cnt_q, load_cnt_d;
  logic       get_q, get_d, enable_q, enable_d;
  logic [7:0] chars_q, chars_d, mistakes_q, mistakes_d;
  logic [4:0] level_q, level_d;
  logic       playing_q, playing_d, game_over_q, game_over_d;
  logic       game_won_q, game_won_d, timeout_q, timeout_d;
  logic       is_make, expired;
  logic [7:0] chars_inc, mistakes_inc;

`ifdef TIMEOUT_EN
  localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_LEVEL - 1);
  logic [31:0] timer_q, timer_d;

  assign expired = (state_q == S_PLAY || state_q == S_SHIFT) && (timer_q == TICK_LAST);

  // Per-word timer: held at zero while a word loads, runs only while the player can type.
  always_comb begin
    timer_d = timer_q;
    if (state_q == S_LOAD) begin
      timer_d = '0;
    end else if (state_q == S_PLAY || state_q == S_SHIFT) begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Timer register.
  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  // Keeps TICKS_PER_LEVEL referenced when the timer is compiled out.
  logic [31:0] unused_ticks;
  assign unused_ticks = 32'(TICKS_PER_LEVEL);
  assign expired      = 1'b0;
`endif

  // Prefix filter: F0/E0 arm a flag, the following byte clears both flags and is discarded.
  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    is_make = 1'b0;
    if (bus.key_valid) begin
      if (bus.key_code == 8'hF0) begin
        brk_d = 1'b1;
      end else if (bus.key_code == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        is_make = 1'b1;
      end
    end
  end

  // Round FSM: next state, counters and the one-cycle parser requests.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    get_d        = 1'b0;
    enable_d     = 1'b0;
    chars_d      = chars_q;
    mistakes_d   = mistakes_q;
    level_d      = level_q;
    game_won_d   = game_won_q;
    timeout_d    = timeout_q;
    chars_inc    = chars_q + 8'd1;
    mistakes_inc = (mistakes_q == 8'hFF) ? 8'hFF : mistakes_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          enable_d   = 1'b1;
          level_d    = '0;
          chars_d    = '0;
          mistakes_d = '0;
          timeout_d  = 1'b0;
          game_won_d = 1'b0;
          load_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_cnt_q == LOAD_LAST) state_d = S_PLAY;
        else                         load_cnt_d = load_cnt_q + 8'd1;
      end
      S_PLAY: begin
        if (is_make && bus.key_code == bus.comparison_data) begin
          get_d   = 1'b1;
          chars_d = chars_inc;
          state_d = (chars_inc == bus.num_char) ? S_NEXT : S_SHIFT;
        end else if (is_make) begin
          mistakes_d = mistakes_inc;
          if (mistakes_inc >= MISTAKE_LIMIT) state_d = S_DONE;
        end
        // A key in the expiry cycle is applied first; only a non-terminal outcome times out.
        if (expired && state_d != S_NEXT && state_d != S_DONE) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (expired) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_NEXT: begin
        if (level_q == LAST_LEVEL) begin
          game_won_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          enable_d   = 1'b1;
          level_d    = level_q + 5'd1;
          chars_d    = '0;
          load_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    playing_d   = (state_d == S_PLAY) || (state_d == S_SHIFT);
    game_over_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      load_cnt_q  <= '0;
      get_q       <= 1'b0;
      enable_q    <= 1'b0;
      chars_q     <= '0;
      mistakes_q  <= '0;
      level_q     <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      game_won_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      load_cnt_q  <= load_cnt_d;
      get_q       <= get_d;
      enable_q    <= enable_d;
      chars_q     <= chars_d;
      mistakes_q  <= mistakes_d;
      level_q     <= level_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      game_won_q  <= game_won_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.get_next_character = get_q;
  assign bus.enable_next_level  = enable_q;
  assign chars_typed            = chars_q;
  assign mistakes               = mistakes_q;
  assign level                  = level_q;
  assign playing                = playing_q;
  assign game_over              = game_over_q;
  assign game_won               = game_won_q;
  assign timeout                = timeout_q;

endmodule

// File: doc/typing_round_controller.md
Name: typing_round_controller

Overview:
- Sequences the keyboard-parser datapath for the speed-typing game.
- Takes decoded PS/2 scan-code bytes and filters out release and extended-prefix bytes.
- Compares each remaining make code against the parser's current comparison_data and pulses get_next_character on a match.
- Counts mistakes and progress against num_char, and pulses enable_next_level to load the next word, for NUM_LEVELS words.

Parameters:
- NUM_LEVELS, 30: words per game; level index runs 0..NUM_LEVELS-1.
- MAX_MISTAKES, 3: mistakes that end the game (loss).
- LOAD_DELAY, 4: idle cycles after an enable_next_level pulse before keys are accepted; covers parser address update plus sequence load.
- TICKS_PER_LEVEL, 500000000: clk cycles allowed per word (TIMEOUT_EN only).

Ports:
- clk  in  1  system clock
- reset  in  1  one clock; reset is synchronous and active-high
- start  in  1  level-sensitive start request, sampled in S_IDLE only
- key_valid  in  1  one-cycle strobe; key_code is valid
- key_code  in  8  raw PS/2 byte
- comparison_data  in  8  expected scan code from the parser
- num_char  in  8  characters in the current word (1..12)
- get_next_character  out  1  one-cycle shift request to the parser
- enable_next_level  out  1  one-cycle level-advance request to the parser
- chars_typed  out  8  correct characters in the current word
- mistakes  out  8  game-wide mismatch count, saturating at 255
- level  out  5  current word index
- playing  out  1  high while in S_PLAY or S_SHIFT
- game_over  out  1  high in S_DONE
- game_won  out  1  valid when game_over is high
- timeout  out  1  sticky; set when the game ends by timer

Behaviour:
- Reset: all outputs 0; state S_IDLE; prefix flags cleared. Reset mid-game aborts on the next edge with no further pulses.
- Prefix filter (runs in all states):
  - 8'hF0 sets brk; the next byte clears brk and is discarded.
  - 8'hE0 sets ext; the next byte clears ext and is discarded.
  - If both flags are set, one following byte clears both.
  - F0 and E0 bytes are never compared.
  - A byte that survives filtering is a "make".
- S_IDLE: on start=1, pulse enable_next_level for 1 cycle, set level=0, clear chars_typed/mistakes/timeout, then go to S_LOAD.
  - The first pulse loads word 0 with no parser address increment.
- S_LOAD: counts LOAD_DELAY cycles, ignoring all makes, then goes to S_PLAY.
  - get_next_character is never asserted here, because the parser gives get priority over load.
- S_PLAY: on a make:
  - If key_code==comparison_data: next cycle, get_next_character=1 and chars_typed+1. If the new count equals num_char, go to S_NEXT; otherwise go to S_SHIFT.
  - If the codes differ: mistakes+1 (saturating). If the new count reaches MAX_MISTAKES, go to S_DONE with game_won=0; otherwise stay in S_PLAY.
  - Latency from key_valid to the get_next_character pulse is exactly 1 cycle.
- S_SHIFT: lasts 1 cycle; any key_valid in this cycle is dropped (comparison_data is stale). Returns to S_PLAY.
- S_NEXT:
  - If level==NUM_LEVELS-1, go to S_DONE with game_won=1 and no enable pulse.
  - Otherwise pulse enable_next_level for 1 cycle, increment level, clear chars_typed, and go to S_LOAD.
- S_DONE: holds game_over=1 and all counters frozen. start is ignored; only reset leaves this state.
- enable_next_level and get_next_character are never high in the same cycle.
- Each of those two outputs is high for at most 1 consecutive cycle.
- All outputs are registered.

Optional Feature:
- TIMEOUT_EN defined:
  - A 32-bit level timer clears on entry to S_LOAD and counts in S_PLAY and S_SHIFT.
  - On reaching TICKS_PER_LEVEL-1, the next state is S_DONE with timeout=1 and game_won=0.
  - If a match or mismatch and expiry occur in the same cycle, the key is applied first: a level-complete match wins over timeout, and a final mistake reports timeout=0.
- TIMEOUT_EN undefined: no timer logic; timeout is tied to 0.

Test Plan:
- Reset, then start=1 with LOAD_DELAY=4 → enable_next_level pulses once; playing=1 on the 5th cycle after the pulse; level=0.
- Word ECF (num_char=3), bench models the parser; feed 8'h24 → F0 → 24 → 21 → F0 → 21 → 2B:
  - get_next_character fires 3 times, each 1 cycle after its make, and never after a break byte.
  - After the third match, one enable pulse; level=1.
- Three makes of 8'h1A against comparison_data 8'h2A → mistakes counts 1, 2, 3; game_over=1, game_won=0; later start pulses are ignored.
- Sequence E0 → 75 while expecting 8'h75 → no match and no mistake; the following plain 8'h75 matches.
- key_valid for a correct code in the S_SHIFT cycle → dropped, no second get; with NUM_LEVELS=2, completing both words → game_won=1 and only 2 enable pulses in total.
- TIMEOUT_EN with TICKS_PER_LEVEL=100 and no keys → timeout=1 and game_over=1 exactly 100 cycles after entering S_PLAY; assert reset mid-S_PLAY → all outputs 0 on the next edge.
